simple_log_buf: RTL
===================

SIMPLE_LOG_BUF -- requirements
Module: simple_log_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log address width; depth = 2**ADDR_W entries.
REQ-002 SHALL have parameter ENTRY_W, default 64, meaning client payload width per log entry.
REQ-003 SHALL have parameter TS_W, default 32, meaning timestamp width; RESP_DATA_STRUCT_W = TS_W+ENTRY_W.
REQ-004 SHALL have ports:
  clk  in  1  sole clock.
  rst_n  in  1  asynchronous, active-low reset.
  log_en  in  1  level; 1 = capture enabled.
  log_clr  in  1  one-cycle pulse; empties the log.
  wr_val  in  1  client entry valid.
  wr_data  in  ENTRY_W  client payload.
  log_rd_req_val  in  1  read request from the NoC reader.
  log_rd_req_addr  in  ADDR_W  read slot.
  log_rd_resp_val  out  1  read data valid.
  log_rd_resp_data  out  TS_W+ENTRY_W  {timestamp, payload}.
  curr_wr_addr  out  ADDR_W  next slot to be written.
  has_wrapped  out  1  write pointer has passed slot depth-1 at least once.
  drop_cnt  out  32  entries discarded while enabled.

Function
REQ-005 SHALL run a free-running TS_W timestamp counter, +1 every cycle, wrapping modulo 2**TS_W.
REQ-006 SHALL, on a write, store {timestamp of that cycle, wr_data} at curr_wr_addr.
REQ-007 SHALL increment curr_wr_addr modulo 2**ADDR_W on every accepted write.
REQ-008 SHALL set has_wrapped in the cycle after a write to slot 2**ADDR_W-1; has_wrapped stays set until log_clr or reset.
REQ-009 SHALL have a state machine with states IDLE, LOG and FULL.
REQ-010 SHALL transition IDLE->LOG when log_en=1 and LOG->IDLE when log_en=0.
REQ-011 SHALL accept a write only when wr_val=1 and the state is LOG; wr_val has no ready and is never back-pressured.
REQ-012 SHALL increment drop_cnt, saturating at 2**32-1, when wr_val=1, log_en=1 and the write is not accepted.
REQ-013 SHALL, on log_clr, clear curr_wr_addr, has_wrapped and drop_cnt to 0, go to IDLE, and discard any write in the same cycle; log_clr has priority over all events and does not alter RAM contents.
REQ-014 SHALL present log_rd_resp_val exactly 1 cycle after log_rd_req_val, with no back-pressure, and accept one request per cycle.
REQ-015 SHALL, on a read and write to the same slot in the same cycle, return the old (pre-write) contents.
REQ-016 SHALL make the read port independent of state, log_en and log_clr.

Reset
REQ-017 SHALL, with rst_n=0, asynchronously force: state IDLE, timestamp 0, curr_wr_addr 0, has_wrapped 0, drop_cnt 0, log_rd_resp_val 0, log_rd_resp_data 0.
REQ-018 SHALL NOT reset RAM contents.
REQ-019 SHALL drop an in-flight read on reset: no log_rd_resp_val follows deassertion.

Configuration
REQ-020 SHALL use macro SIMPLE_LOG_STOP_ON_FULL_EN.
REQ-021 SHALL, with SIMPLE_LOG_STOP_ON_FULL_EN defined, enter FULL on the write to slot 2**ADDR_W-1; FULL accepts no writes (counted as drops while log_en=1) and exits only via log_clr or reset.
REQ-022 SHALL, without SIMPLE_LOG_STOP_ON_FULL_EN, never enter FULL and wrap, overwriting the oldest entries.

Structure
REQ-023 SHALL place the state enum, the entry struct {ts, payload} and width helpers in shared package simple_log_pkg.
REQ-024 SHALL instantiate one sub-module, simple_log_ram: 1R1W, registered read, read-first.

Verification (ADDR_W=3, ENTRY_W=32, TS_W=16)
REQ-025 SHALL check basic capture: log_en=1, 3 writes of 0xA0..0xA2 -> curr_wr_addr=3, has_wrapped=0; reads of slots 0..2 return payload 0xA0..0xA2 with increasing timestamps, valid 1 cycle after each request.
REQ-026 SHALL check wrap: 10 writes without the macro -> curr_wr_addr=2, has_wrapped=1; slot 0 holds the 9th entry.
REQ-027 SHALL check stop-on-full: 10 writes with the macro -> state FULL, curr_wr_addr=0, has_wrapped=1, drop_cnt=2; slot 0 holds the 1st entry.
REQ-028 SHALL check read/write collision: write 0xBB to slot 4 while reading slot 4 (previously 0xAA) -> response 0xAA; next read returns 0xBB.
REQ-029 SHALL check clear: log_clr pulsed together with wr_val -> curr_wr_addr=0, has_wrapped=0, drop_cnt=0, state IDLE; the concurrent write is not stored.
REQ-030 SHALL check reset mid-operation: assert rst_n=0 the cycle after a read request -> log_rd_resp_val stays 0; all outputs reach their reset values immediately.

Source files
------------

// File: rtl/simple_log_pkg.sv
// simple_log_pkg
// Shared definitions for the simple_log_buf slice: the capture state
// encoding, the layout of one stored log entry and width helpers.
// Optional feature macro used by this slice: SIMPLE_LOG_STOP_ON_FULL_EN.
package simple_log_pkg;

    // Capture state. FULL is only ever entered in stop-on-full builds.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOG  = 2'd1,
        ST_FULL = 2'd2
    } log_state_e;

    localparam int DEF_TS_W    = 32;
    localparam int DEF_ENTRY_W = 64;
    localparam int DROP_CNT_W  = 32;

    // One log entry at default widths; the timestamp sits above the payload.
    // Parameterised modules build the same {ts, payload} layout locally.
    typedef struct packed {
        logic [DEF_TS_W-1:0]    ts;
        logic [DEF_ENTRY_W-1:0] payload;
    } log_entry_t;

    // Width of the {timestamp, payload} word returned by the read port.
    function automatic int resp_data_struct_w(input int ts_w, input int entry_w);
        return ts_w + entry_w;
    endfunction

endpackage

// File: rtl/simple_log_ram.sv
// simple_log_ram
// 1R1W storage for the log. Registered, read-first read port: a read and a
// write to the same slot in one cycle return the pre-write contents.
// The array itself is never reset; only the read data register is.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (read register only)
//   wr_en/addr/data   write port
//   rd_en/addr        read request, data appears on rd_data next cycle
//   rd_data           registered read data
module simple_log_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-first falls out of the non-blocking update: mem still holds the
    // old word when it is sampled here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/simple_log_buf.sv
// simple_log_buf
// Timestamped circular capture log. Client entries are stored as
// {timestamp, payload} while logging is enabled; a separate read port lets a
// NoC reader fetch any slot with a fixed one-cycle latency.
// Optional feature: define SIMPLE_LOG_STOP_ON_FULL_EN to freeze the log once
// the last slot is written instead of wrapping over the oldest entries.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   log_en                level, capture enable
//   log_clr               one-cycle pulse, empties the log (RAM untouched)
//   wr_val, wr_data       client entry (never back-pressured)
//   log_rd_req_val/addr   read request
//   log_rd_resp_val/data  read response, one cycle after the request
//   curr_wr_addr          next slot to be written
//   has_wrapped           last slot has been written at least once
//   drop_cnt              saturating count of entries discarded while enabled
module simple_log_buf
    import simple_log_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int ENTRY_W = 64,
    parameter int TS_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    log_en,
    input  logic                    log_clr,
    input  logic                    wr_val,
    input  logic [ENTRY_W-1:0]      wr_data,
    input  logic                    log_rd_req_val,
    input  logic [ADDR_W-1:0]       log_rd_req_addr,
    output logic                    log_rd_resp_val,
    output logic [TS_W+ENTRY_W-1:0] log_rd_resp_data,
    output logic [ADDR_W-1:0]       curr_wr_addr,
    output logic                    has_wrapped,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int RESP_W = resp_data_struct_w(TS_W, ENTRY_W);

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [ENTRY_W-1:0] payload;
    } entry_t;

    log_state_e      state;
    log_state_e      next_state;
    logic [TS_W-1:0] ts;
    logic            wr_accept;
    logic            wr_last;
    logic            drop_event;
    entry_t          wr_entry;

    // A clear discards any write presented alongside it.
    assign wr_accept  = wr_val && (state == ST_LOG) && !log_clr;
    assign wr_last    = wr_accept && (curr_wr_addr == {ADDR_W{1'b1}});
    // Anything offered while enabled but not taken is a drop, including the
    // first enabled cycle (still IDLE) and every write while FULL.
    assign drop_event = wr_val && log_en && (state != ST_LOG);

    assign wr_entry.ts      = ts;
    assign wr_entry.payload = wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FULL is sticky against log_en; only a clear (or reset) leaves it.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (log_en) begin
                    next_state = ST_LOG;
                end
            end
            ST_LOG: begin
                if (!log_en) begin
                    next_state = ST_IDLE;
                end
`ifdef SIMPLE_LOG_STOP_ON_FULL_EN
                if (wr_last) begin
                    next_state = ST_FULL;
                end
`endif
            end
            ST_FULL: begin
`ifdef SIMPLE_LOG_STOP_ON_FULL_EN
                next_state = ST_FULL;
`else
                next_state = ST_IDLE;
`endif
            end
            default: next_state = ST_IDLE;
        endcase
        if (log_clr) begin
            next_state = ST_IDLE;
        end
    end

    // Free-running timestamp, unaffected by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_wr_addr <= '0;
            has_wrapped  <= 1'b0;
        end else if (log_clr) begin
            curr_wr_addr <= '0;
            has_wrapped  <= 1'b0;
        end else if (wr_accept) begin
            curr_wr_addr <= curr_wr_addr + 1'b1;
            if (wr_last) begin
                has_wrapped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (log_clr) begin
            drop_cnt <= '0;
        end else if (drop_event && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Read port ignores state, enable and clear entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_rd_resp_val <= 1'b0;
        end else begin
            log_rd_resp_val <= log_rd_req_val;
        end
    end

    simple_log_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RESP_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (curr_wr_addr),
        .wr_data (wr_entry),
        .rd_en   (log_rd_req_val),
        .rd_addr (log_rd_req_addr),
        .rd_data (log_rd_resp_data)
    );

endmodule
